// File: rtl/alu_muldiv_pkg.sv
// Shared types for the ALU / iterative multiply-divide block.
package alu_muldiv_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_AND   = 4'b0010,
        OP_OR    = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_SLT   = 4'b0101,
        OP_SLTU  = 4'b0110,
        OP_SLL   = 4'b0111,
        OP_SRL   = 4'b1000,
        OP_SRA   = 4'b1001,
        OP_MUL   = 4'b1010,
        OP_MULHU = 4'b1011,
        OP_DIVU  = 4'b1100,
        OP_REMU  = 4'b1101,
        OP_ILL0  = 4'b1110,
        OP_ILL1  = 4'b1111
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier and restoring divider sharing one register set.
module alu_muldiv_iter
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic             sel_hi,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = SHW + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    // mul: hi = upper product, lo = multiplier shifting out, opnd = multiplicand
    // div: hi = partial remainder, lo = dividend shifting into quotient, opnd = divisor
    logic             busy_q, busy_d;
    logic             is_div_q, is_div_d;
    logic             sel_hi_q, sel_hi_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] hi_step;
    logic [WIDTH-1:0] lo_step;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_sh    = {hi_q, lo_q[WIDTH-1]};
        div_trial = div_sh - {1'b0, opnd_q};

        if (is_div_q) begin
            if (!div_trial[WIDTH]) begin
                hi_step = div_trial[WIDTH-1:0];
                lo_step = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_step = div_sh[WIDTH-1:0];
                lo_step = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_step = mul_sum[WIDTH:1];
            lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
        end

        done   = busy_q && (cnt_q == CNT_LAST);
        // mulhu and remu both live in hi; mul and divu in lo
        result = sel_hi_q ? hi_step : lo_step;

        busy_d   = busy_q;
        is_div_d = is_div_q;
        sel_hi_d = sel_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;

        if (start) begin
            busy_d   = 1'b1;
            is_div_d = is_div;
            sel_hi_d = sel_hi;
            hi_d     = '0;
            lo_d     = is_div ? a : b;
            opnd_d   = is_div ? b : a;
            cnt_d    = '0;
        end else if (busy_q) begin
            hi_d  = hi_step;
            lo_d  = lo_step;
            cnt_d = done ? '0 : cnt_q + 1'b1;
            if (done) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q   <= 1'b0;
            is_div_q <= 1'b0;
            sel_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            is_div_q <= is_div_d;
            sel_hi_q <= sel_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// ALU with single-cycle ops and an iterative multiply/divide path behind a small FSM.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alucontrol,
    input  logic             valid_in,
    output logic             ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             valid_out,
    output logic             v,
    output logic             illegal
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             v_q, v_d;
    logic             illegal_q, illegal_d;
    logic             valid_q, valid_d;

    opcode_e          op;
    logic [SHW-1:0]   shamt;
    logic             is_sub;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_v;
    logic             alu_ill;
    logic             is_mul_op;
    logic             is_div_op;
    logic             sel_hi;
    logic             accept;
    logic             iter_start;
    logic             iter_done;
    logic [WIDTH-1:0] iter_res;

    always_comb begin
        op        = opcode_e'(alucontrol);
        shamt     = b[SHW-1:0];
        is_sub    = (op == OP_SUB);
        sum       = a + (is_sub ? ~b : b) + {{(WIDTH-1){1'b0}}, is_sub};
        alu_v     = 1'b0;
        alu_ill   = 1'b0;
        alu_res   = '0;
        case (op)
            OP_ADD, OP_SUB: begin
                alu_res = sum;
                alu_v   = ~(is_sub ^ a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ sum[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
            OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: alu_res = '0;
            default: alu_ill = 1'b1;
        endcase

        is_mul_op  = (op == OP_MUL)  || (op == OP_MULHU);
        is_div_op  = (op == OP_DIVU) || (op == OP_REMU);
        sel_hi     = (op == OP_MULHU) || (op == OP_REMU);
        accept     = valid_in && (state_q == S_IDLE);
        iter_start = accept && (is_mul_op || is_div_op);
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        v_d       = v_q;
        illegal_d = illegal_q;
        valid_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_mul_op) begin
                        state_d = S_MUL;
                    end else if (is_div_op) begin
                        state_d = S_DIV;
                    end else begin
                        result_d  = alu_res;
                        zero_d    = (alu_res == '0);
                        v_d       = alu_v;
                        illegal_d = alu_ill;
                        valid_d   = 1'b1;
                    end
                end
            end
            S_MUL, S_DIV: begin
                // capture on the final iteration edge so valid_out lands in DONE
                if (iter_done) begin
                    result_d  = iter_res;
                    zero_d    = (iter_res == '0);
                    v_d       = 1'b0;
                    illegal_d = 1'b0;
                    valid_d   = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            v_q       <= 1'b0;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            v_q       <= v_d;
            illegal_q <= illegal_d;
            valid_q   <= valid_d;
        end
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_iter (
        .clk    (clk),
        .reset  (reset),
        .start  (iter_start),
        .is_div (is_div_op),
        .sel_hi (sel_hi),
        .a      (a),
        .b      (b),
        .done   (iter_done),
        .result (iter_res)
    );

    assign ready     = (state_q == S_IDLE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign v         = v_q;
    assign illegal   = illegal_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench: expected results queued at issue, checked when valid_out pulses.
module tb_alu_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] a, b;
    logic [3:0]   alucontrol;
    logic         valid_in;
    logic         ready;
    logic [W-1:0] result;
    logic         zero, valid_out, v, illegal;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .alucontrol (alucontrol),
        .valid_in   (valid_in),
        .ready      (ready),
        .result     (result),
        .zero       (zero),
        .valid_out  (valid_out),
        .v          (v),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         v;
        logic         ill;
        int           due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t         e;
        logic [W-1:0] r;
        logic [63:0]  p;
        logic         ov;
        logic         ill;
        ov  = 1'b0;
        ill = 1'b0;
        p   = {32'd0, x} * {32'd0, y};
        case (op)
            4'd0:  begin r = x + y; ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]); end
            4'd1:  begin r = x - y; ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]); end
            4'd2:  r = x & y;
            4'd3:  r = x | y;
            4'd4:  r = x ^ y;
            4'd5:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd6:  r = (x < y) ? 32'd1 : 32'd0;
            4'd7:  r = x << y[4:0];
            4'd8:  r = x >> y[4:0];
            4'd9:  r = $unsigned($signed(x) >>> y[4:0]);
            4'd10: r = p[31:0];
            4'd11: r = p[63:32];
            4'd12: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            4'd13: r = (y == 0) ? x : x % y;
            default: begin r = '0; ill = 1'b1; end
        endcase
        e.res = r;
        e.z   = (r == 0);
        e.v   = ov;
        e.ill = ill;
        e.due = 0;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit track = 1'b1);
        int   t;
        exp_t e;
        t = 0;
        while (!ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!ready) chk("ready_timeout", 64'd0, 64'd1);
        alucontrol = op;
        a          = x;
        b          = y;
        valid_in   = 1'b1;
        if (track) begin
            e     = model(op, x, y);
            e.due = cyc + 1 + ((op >= 4'd10 && op <= 4'd13) ? W : 0);
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!reset && valid_out) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("result",  result,  mon_e.res);
                chk("zero",    zero,    mon_e.z);
                chk("v",       v,       mon_e.v);
                chk("illegal", illegal, mon_e.ill);
                chk("latency", cyc,     mon_e.due);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int busy;
        int t;
        reset      = 1'b1;
        valid_in   = 1'b0;
        a          = '0;
        b          = '0;
        alucontrol = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_result",  result,    64'd0);
        chk("rst_zero",    zero,      64'd0);
        chk("rst_v",       v,         64'd0);
        chk("rst_illegal", illegal,   64'd0);
        chk("rst_valid",   valid_out, 64'd0);
        chk("rst_ready",   ready,     64'd1);

        // add/sub overflow and zero flag
        send(4'd1, 32'h8000_0000, 32'd1);
        send(4'd0, 32'h7FFF_FFFF, 32'd1);
        send(4'd1, 32'd5, 32'd5);
        send(4'd0, 32'hFFFF_FFFF, 32'd1);
        idle(2);

        // mulhu: count busy cycles
        send(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        valid_in = 1'b0;
        busy = 1;
        while (!ready && busy < 100) begin
            @(negedge clk);
            if (!ready) busy++;
        end
        chk("mulhu_busy_cycles", busy, 64'd33);

        // mul, with valid_in held while busy (must be ignored)
        send(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        alucontrol = 4'd0;
        a          = 32'd7;
        b          = 32'd9;
        valid_in   = 1'b1;
        repeat (5) @(negedge clk);
        chk("ready_low_while_busy", ready, 64'd0);
        valid_in = 1'b0;

        send(4'd12, 32'd100, 32'd7);
        send(4'd13, 32'd100, 32'd7);
        send(4'd12, 32'd1234, 32'd0);
        send(4'd13, 32'd5, 32'd0);

        // shifts and compares, back-to-back
        send(4'd9, 32'h8000_0000, 32'h0000_0024);
        send(4'd7, 32'h0000_0001, 32'h0000_001F);
        send(4'd8, 32'h8000_0000, 32'h0000_0021);
        send(4'd5, 32'hFFFF_FFFF, 32'd0);
        send(4'd6, 32'hFFFF_FFFF, 32'd0);
        send(4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF);
        send(4'd3, 32'hF000_0000, 32'h0000_000F);
        send(4'd4, 32'hAAAA_AAAA, 32'hAAAA_AAAA);
        send(4'd15, 32'd1, 32'd2);
        send(4'd14, 32'd3, 32'd4);
        idle(2);

        for (int i = 0; i < 30; i++) begin
            send(4'($urandom_range(0, 15)), $urandom, (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom);
        end
        idle(1);
        t = 0;
        while (sb.size() > 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_before_reset", sb.size(), 64'd0);

        // reset during divide iteration 10
        send(4'd12, 32'd1000, 32'd3, 1'b0);
        valid_in = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_ready",  ready,     64'd1);
        chk("midrst_valid",  valid_out, 64'd0);
        chk("midrst_result", result,    64'd0);
        reset = 1'b0;
        send(4'd0, 32'd2, 32'd3);
        idle(40);

        chk("scoreboard_empty", sb.size(), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
